// File: rtl/dequantization.sv
// JPEG luminance dequantizer: one 8-coefficient row per handshake, coef * Q[row][col] rescaled
// into 16.16 fixed point with saturation, over a two-stage elastic pipeline.
module dequantization #(
    parameter int PIX_IN_WIDTH  = 16,
    parameter int PIX_OUT_WIDTH = 32,
    parameter int FRAC_BITS     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PIX_IN_WIDTH*8-1:0]  data_in_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PIX_OUT_WIDTH*8-1:0] data_out_o,
    output logic [2:0]                 row_o,
    output logic                       last_o,
    output logic                       sat_o
);

    localparam int P_W = PIX_IN_WIDTH + 7;
    localparam int V_W = P_W + FRAC_BITS;

    localparam logic [7:0] Q_TAB [64] = '{
        8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
        8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
        8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
        8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
        8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
        8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
        8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
        8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
    };

    // Quantizer entries are positive, so they enter the signed multiply zero-extended.
    function automatic logic signed [P_W-1:0] mul_q(input logic signed [PIX_IN_WIDTH-1:0] coef,
                                                   input logic [7:0] q);
        logic signed [P_W-1:0] a;
        logic signed [P_W-1:0] b;
        a = {{(P_W-PIX_IN_WIDTH){coef[PIX_IN_WIDTH-1]}}, coef};
        b = {{(P_W-8){1'b0}}, q};
        return a * b;
    endfunction

    // Returns {saturated, lane}: the value fits only if all bits above the output sign bit match it.
    function automatic logic [PIX_OUT_WIDTH:0] sat_shift(input logic signed [P_W-1:0] p);
        logic signed [V_W-1:0]       v;
        logic [V_W-PIX_OUT_WIDTH:0]  hi;
        v  = {p, {FRAC_BITS{1'b0}}};
        hi = v[V_W-1:PIX_OUT_WIDTH-1];
        if ((hi == '0) || (hi == '1)) begin
            return {1'b0, v[PIX_OUT_WIDTH-1:0]};
        end else if (v[V_W-1]) begin
            return {1'b1, 1'b1, {(PIX_OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b1, 1'b0, {(PIX_OUT_WIDTH-1){1'b1}}};
        end
    endfunction

    logic                        en_s;
    logic                        accept_s;
    logic [2:0]                  row_cnt_q, row_cnt_d;
    logic                        s1_valid_q, s1_valid_d;
    logic [2:0]                  s1_row_q, s1_row_d;
    logic signed [P_W-1:0]       s1_p_q [8];
    logic signed [P_W-1:0]       s1_p_d [8];
    logic                        out_valid_q, out_valid_d;
    logic [PIX_OUT_WIDTH*8-1:0]  data_q, data_d;
    logic [2:0]                  row_q, row_d;
    logic                        last_q, last_d;
    logic                        sat_q, sat_d;
    logic [PIX_OUT_WIDTH*8-1:0]  lane_data_s;
    logic [7:0]                  lane_sat_s;

    assign en_s        = !out_valid_q || out_ready_i;
    assign accept_s    = in_valid_i && en_s && !clr_i;
    assign in_ready_o  = en_s;
    assign out_valid_o = out_valid_q;
    assign data_out_o  = data_q;
    assign row_o       = row_q;
    assign last_o      = last_q;
    assign sat_o       = sat_q;

    // Stage 1: row counter and per-lane products on accept.
    always_comb begin
        row_cnt_d  = row_cnt_q;
        s1_valid_d = s1_valid_q;
        s1_row_d   = s1_row_q;
        s1_p_d     = s1_p_q;
        if (clr_i) begin
            row_cnt_d  = 3'd0;
            s1_valid_d = 1'b0;
        end else if (en_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                row_cnt_d = row_cnt_q + 3'd1;
                s1_row_d  = row_cnt_q;
                for (int c = 0; c < 8; c++) begin
                    s1_p_d[c] = mul_q(data_in_i[c*PIX_IN_WIDTH +: PIX_IN_WIDTH],
                                      Q_TAB[{row_cnt_q, 3'(c)}]);
                end
            end else begin
                s1_row_d = s1_row_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 datapath: shift into the fixed-point domain and clamp each lane.
    always_comb begin
        lane_data_s = '0;
        lane_sat_s  = 8'd0;
        for (int c = 0; c < 8; c++) begin
            {lane_sat_s[c], lane_data_s[c*PIX_OUT_WIDTH +: PIX_OUT_WIDTH]} = sat_shift(s1_p_q[c]);
        end
    end

    // Stage 2 output register; data and row hold across bubbles, last/sat only flag valid rows.
    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        row_d       = row_q;
        last_d      = last_q;
        sat_d       = sat_q;
        if (clr_i) begin
            out_valid_d = 1'b0;
            data_d      = '0;
            row_d       = 3'd0;
            last_d      = 1'b0;
            sat_d       = 1'b0;
        end else if (en_s) begin
            out_valid_d = s1_valid_q;
            last_d      = s1_valid_q && (s1_row_q == 3'd7);
            sat_d       = s1_valid_q && (|lane_sat_s);
            if (s1_valid_q) begin
                data_d = lane_data_s;
                row_d  = s1_row_q;
            end else begin
                data_d = data_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_cnt_q   <= 3'd0;
            s1_valid_q  <= 1'b0;
            s1_row_q    <= 3'd0;
            for (int c = 0; c < 8; c++) begin
                s1_p_q[c] <= '0;
            end
            out_valid_q <= 1'b0;
            data_q      <= '0;
            row_q       <= 3'd0;
            last_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            row_cnt_q   <= row_cnt_d;
            s1_valid_q  <= s1_valid_d;
            s1_row_q    <= s1_row_d;
            s1_p_q      <= s1_p_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            row_q       <= row_d;
            last_q      <= last_d;
            sat_q       <= sat_d;
        end
    end

endmodule

// File: tb/tb_dequantization.sv
// Self-checking bench for dequantization: directed vector table, hand sequences for
// latency/backpressure/clear/reset, and a randomized run against a queue-based reference model.
module tb_dequantization;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         clr_i = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [127:0] data_in_i = 128'd0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [255:0] data_out_o;
    logic [2:0]   row_o;
    logic         last_o;
    logic         sat_o;

    dequantization dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .data_in_i(data_in_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data_out_o(data_out_o),
        .row_o(row_o), .last_o(last_o), .sat_o(sat_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    int QT [8][8] = '{
        '{16, 11, 10, 16, 24, 40, 51, 61},
        '{12, 12, 14, 19, 26, 58, 60, 55},
        '{14, 13, 16, 24, 40, 57, 69, 56},
        '{14, 17, 22, 29, 51, 87, 80, 62},
        '{18, 22, 37, 56, 68, 109, 103, 77},
        '{24, 35, 55, 64, 81, 104, 113, 92},
        '{49, 64, 78, 87, 103, 121, 120, 101},
        '{72, 92, 95, 98, 112, 100, 103, 99}
    };

    typedef struct {
        logic [255:0] d;
        logic [2:0]   r;
        logic         l;
        logic         s;
    } exp_t;

    typedef struct {
        logic [127:0] coefs;
        logic [255:0] exp;
        logic         sat;
    } vec_t;

    exp_t         mdl_q [$];
    int           mdl_row = 0;
    logic         hold_pending = 1'b0;
    logic [255:0] hold_data;
    logic [2:0]   hold_row;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void ref_row(input logic [127:0] coefs, input int r,
                                    output logic [255:0] d, output logic s);
        longint v;
        d = 256'd0;
        s = 1'b0;
        for (int c = 0; c < 8; c++) begin
            v = longint'($signed(coefs[c*16 +: 16])) * longint'(QT[r][c]) * 64'sd65536;
            if (v > 64'sd2147483647) begin
                d[c*32 +: 32] = 32'h7FFFFFFF;
                s = 1'b1;
            end else if (v < -64'sd2147483648) begin
                d[c*32 +: 32] = 32'h80000000;
                s = 1'b1;
            end else begin
                d[c*32 +: 32] = v[31:0];
            end
        end
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle when all signals are settled.
    always @(negedge clk_i) begin
        exp_t e;
        if (rst_i) begin
            mdl_q.delete();
            mdl_row = 0;
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_data", data_out_o, hold_data);
                check("hold_row", {253'd0, row_o}, {253'd0, hold_row});
                check("hold_valid", {255'd0, out_valid_o}, 256'd1);
            end
            hold_pending = out_valid_o && !out_ready_i && !clr_i;
            hold_data    = data_out_o;
            hold_row     = row_o;
            check("in_ready", {255'd0, in_ready_o}, {255'd0, (!out_valid_o || out_ready_i)});
            if (out_valid_o && out_ready_i) begin
                if (mdl_q.size() == 0) begin
                    check("unexpected_row", {255'd0, out_valid_o}, 256'd0);
                end else begin
                    e = mdl_q.pop_front();
                    check("sb_data", data_out_o, e.d);
                    check("sb_row", {253'd0, row_o}, {253'd0, e.r});
                    check("sb_last", {255'd0, last_o}, {255'd0, e.l});
                    check("sb_sat", {255'd0, sat_o}, {255'd0, e.s});
                end
            end
            if (clr_i) begin
                mdl_q.delete();
                mdl_row = 0;
            end else if (in_valid_i && in_ready_o) begin
                ref_row(data_in_i, mdl_row, e.d, e.s);
                e.r = 3'(mdl_row);
                e.l = (mdl_row == 7);
                mdl_q.push_back(e);
                mdl_row = (mdl_row + 1) % 8;
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        clr_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic check_zero(input string name);
        check({name, "_valid"}, {255'd0, out_valid_o}, 256'd0);
        check({name, "_data"}, data_out_o, 256'd0);
        check({name, "_row"}, {253'd0, row_o}, 256'd0);
        check({name, "_last_sat"}, {254'd0, last_o, sat_o}, 256'd0);
    endtask

    // Send one row of all-ones and check its output two cycles later.
    task automatic single_ones_row(input string name);
        in_valid_i = 1'b1;
        data_in_i  = {8{16'd1}};
        tick();
        in_valid_i = 1'b0;
        tick();
        check({name, "_valid"}, {255'd0, out_valid_o}, 256'd1);
        check({name, "_lane0"}, {224'd0, data_out_o[31:0]}, {224'd0, 32'h00100000});
        check({name, "_row"}, {253'd0, row_o}, 256'd0);
    endtask

    vec_t tbl [10];

    initial begin
        int lat;
        int r;
        tbl[0] = '{{8{16'd1}},
                   {32'h003D0000, 32'h00330000, 32'h00280000, 32'h00180000,
                    32'h00100000, 32'h000A0000, 32'h000B0000, 32'h00100000}, 1'b0};
        tbl[1] = '{{112'd0, 16'd32767}, {224'd0, 32'h7FFFFFFF}, 1'b1};
        tbl[2] = '{{112'd0, 16'h8000}, {224'd0, 32'h80000000}, 1'b1};
        tbl[3] = '{128'd0, 256'd0, 1'b0};
        tbl[4] = '{{32'd0, 16'd1, 80'd0}, {64'd0, 32'h006D0000, 160'd0}, 1'b0};
        tbl[5] = '{{112'd0, 16'hFFFF}, {224'd0, 32'hFFE80000}, 1'b0};
        tbl[6] = '{{16'd2, 112'd0}, {32'h00CA0000, 224'd0}, 1'b0};
        tbl[7] = '{{16'hFFFD, 112'd0}, {32'hFED70000, 224'd0}, 1'b0};
        tbl[8] = '{{64'd0, 16'hF800, 32'd0, 16'd2047},
                   {128'd0, 32'h80000000, 64'd0, 32'h7FF00000}, 1'b0};
        tbl[9] = '{{112'd0, 16'd2731}, {224'd0, 32'h7FFFFFFF}, 1'b1};

        #2;
        check_zero("reset");
        check("reset_in_ready", {255'd0, in_ready_o}, 256'd1);
        do_reset();

        // Directed vectors, one row at a time, with latency measured.
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1;
            data_in_i  = tbl[i].coefs;
            tick();
            in_valid_i = 1'b0;
            lat = 1;
            while (!out_valid_o && lat < 10) begin
                tick();
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 256'(lat), 256'd2);
            check($sformatf("vec%0d_data", i), data_out_o, tbl[i].exp);
            check($sformatf("vec%0d_row", i), {253'd0, row_o}, 256'(i % 8));
            check($sformatf("vec%0d_last", i), {255'd0, last_o}, {255'd0, (i % 8) == 7});
            check($sformatf("vec%0d_sat", i), {255'd0, sat_o}, {255'd0, tbl[i].sat});
            tick();
        end

        // Nine back-to-back rows of 2: full block then wrap to row 0.
        do_reset();
        for (int t = 0; t < 12; t++) begin
            in_valid_i = (t < 9);
            data_in_i  = {8{16'd2}};
            tick();
            if (t >= 1 && t <= 9) begin
                r = t - 1;
                check($sformatf("b2b%0d_valid", t), {255'd0, out_valid_o}, 256'd1);
                check($sformatf("b2b%0d_row", t), {253'd0, row_o}, 256'(r % 8));
                check($sformatf("b2b%0d_last", t), {255'd0, last_o}, {255'd0, r == 7});
                if (r == 7) begin
                    check("b2b_row7_c7", {224'd0, data_out_o[255:224]}, {224'd0, 32'h00C60000});
                end
            end else if (t >= 10) begin
                check($sformatf("b2b%0d_idle", t), {255'd0, out_valid_o}, 256'd0);
            end
        end

        // Backpressure: fill the pipe, stall three cycles, release.
        do_reset();
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_in_i = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        data_in_i = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d_in_ready", i), {255'd0, in_ready_o}, 256'd0);
            check($sformatf("stall%0d_row", i), {253'd0, row_o}, 256'd0);
        end
        out_ready_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("stall_drained", 256'(mdl_q.size()), 256'd0);

        // Clear after three rows, then a fresh row restarts at row 0.
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            data_in_i  = {8{16'd5}};
            tick();
        end
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        in_valid_i = 1'b0;
        check_zero("clr");
        tick();
        check("clr_flushed", {255'd0, out_valid_o}, 256'd0);
        single_ones_row("after_clr");
        tick();

        // Reset mid-block.
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1;
            data_in_i  = {8{16'd7}};
            tick();
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        check_zero("midrst");
        rst_i = 1'b0;
        single_ones_row("after_rst");
        tick();

        // Randomized traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            clr_i       = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < 8; c++) begin
                case ($urandom_range(0, 5))
                    0: data_in_i[c*16 +: 16] = 16'h7FFF;
                    1: data_in_i[c*16 +: 16] = 16'h8000;
                    2: data_in_i[c*16 +: 16] = 16'(($urandom_range(0, 4000)) - 2000);
                    default: data_in_i[c*16 +: 16] = 16'($urandom);
                endcase
            end
            tick();
        end
        in_valid_i  = 1'b0;
        clr_i       = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("random_drained", 256'(mdl_q.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
